// File: rtl/logic_op_sequencer.sv
// rtl/logic_op_sequencer.sv - three-state command sequencer around an external combinational logic unit
//
// Accepts one command (operands + op select), holds it on the logic-unit
// inputs for SETTLE cycles, captures the unit's result, and presents it
// downstream until it is taken.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready, in_a/in_b/in_sel   command handshake and payload
//   lu_a/lu_b/lu_sel  (out)         registered operands to the logic unit
//   lu_y              (in)          logic-unit result
//   out_valid/out_ready, out_y/out_sel    result handshake and payload
//   op_count                        completed output handshakes, wraps at 256
module logic_op_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_a,
    input  logic [1:0] in_b,
    input  logic       in_sel,
    output logic [1:0] lu_a,
    output logic [1:0] lu_b,
    output logic       lu_sel,
    input  logic [3:0] lu_y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_y,
    output logic       out_sel,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] count;

    // Handshake flags depend on the state register only, so there is no
    // combinational path from any input to in_ready or out_valid.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= 4'd0;
            lu_a     <= 2'd0;
            lu_b     <= 2'd0;
            lu_sel   <= 1'b0;
            out_y    <= 4'd0;
            out_sel  <= 1'b0;
            op_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        lu_a   <= in_a;
                        lu_b   <= in_b;
                        lu_sel <= in_sel;
                        count  <= SETTLE_LOAD;
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    // The logic unit has had SETTLE cycles on stable operands
                    // once the counter reaches zero; that is the only edge
                    // where lu_y is sampled.
                    if (count == 4'd0) begin
                        out_y   <= lu_y;
                        out_sel <= lu_sel;
                        state   <= HOLD;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        op_count <= op_count + 8'd1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_sequencer.sv
// tb/tb_logic_op_sequencer.sv - directed table-driven bench for logic_op_sequencer
module tb_logic_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_a;
    logic [1:0] in_b;
    logic       in_sel;
    logic [1:0] lu_a;
    logic [1:0] lu_b;
    logic       lu_sel;
    logic [3:0] lu_y;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_y;
    logic       out_sel;
    logic [7:0] op_count;

    logic [3:0] noise;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    // Live logic unit: ~(A&B) or ~A on zero-extended 2-bit operands, with an
    // optional disturbance to show lu_y is only sampled on the capture edge.
    assign lu_y = (lu_sel ? ~{2'b00, lu_a} : ~({2'b00, lu_a} & {2'b00, lu_b})) ^ noise;

    logic_op_sequencer #(.SETTLE(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sel   (in_sel),
        .lu_a     (lu_a),
        .lu_b     (lu_b),
        .lu_sel   (lu_sel),
        .lu_y     (lu_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y),
        .out_sel  (out_sel),
        .op_count (op_count)
    );

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       sel;
        logic [3:0] y;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full command with out_ready held low until the result is checked.
    task automatic run_cmd(input logic [1:0] a, input logic [1:0] b, input logic sel,
                           input logic [3:0] y);
        @(negedge clk);
        in_a = a; in_b = b; in_sel = sel; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);                    // edge N: accept
        @(negedge clk);
        in_valid = 1'b0;
        chk("out_valid_n", out_valid, 0);
        chk("lu_a", lu_a, a);
        chk("lu_b", lu_b, b);
        chk("lu_sel", lu_sel, sel);
        @(posedge clk);                    // edge N+1
        @(negedge clk);
        chk("out_valid_n1", out_valid, 0);
        @(posedge clk);                    // edge N+2: capture
        @(negedge clk);
        chk("out_valid_n2", out_valid, 1);
        chk("out_y", out_y, y);
        chk("out_sel", out_sel, sel);
        noise = 4'hF;
        @(posedge clk);
        @(negedge clk);
        chk("out_y_hold", out_y, y);
        noise = 4'h0;
        out_ready = 1'b1;
        @(posedge clk);                    // output handshake
        @(negedge clk);
        out_ready = 1'b0;
        exp_count = (exp_count + 1) % 256;
        chk("out_valid_after_hs", out_valid, 0);
        chk("in_ready_after_hs", in_ready, 1);
        chk("op_count", op_count, exp_count);
    endtask

    initial begin
        int last_pulse;
        int pulses;

        vecs[0] = '{a: 2'b11, b: 2'b01, sel: 1'b0, y: 4'hE};
        vecs[1] = '{a: 2'b10, b: 2'b00, sel: 1'b1, y: 4'hD};
        vecs[2] = '{a: 2'b00, b: 2'b00, sel: 1'b0, y: 4'hF};
        vecs[3] = '{a: 2'b11, b: 2'b11, sel: 1'b0, y: 4'hC};
        vecs[4] = '{a: 2'b01, b: 2'b10, sel: 1'b0, y: 4'hF};
        vecs[5] = '{a: 2'b11, b: 2'b00, sel: 1'b1, y: 4'hC};
        vecs[6] = '{a: 2'b01, b: 2'b01, sel: 1'b0, y: 4'hE};
        vecs[7] = '{a: 2'b00, b: 2'b11, sel: 1'b1, y: 4'hF};

        rst_n = 1'b0; in_valid = 1'b0; in_a = 2'd0; in_b = 2'd0; in_sel = 1'b0;
        out_ready = 1'b0; noise = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_lu_a", lu_a, 0);
        rst_n = 1'b1;

        // IDLE with in_valid low must hold
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_hold_in_ready", in_ready, 1);
        chk("idle_hold_lu_a", lu_a, 0);

        for (int i = 0; i < 8; i++)
            run_cmd(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].y);

        // Stall in HOLD with in_valid pending and lu_y disturbed
        @(negedge clk);
        in_a = 2'b11; in_b = 2'b01; in_sel = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_a = 2'b00; in_b = 2'b00; in_sel = 1'b1;   // new command held pending
        @(posedge clk);
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            noise = 4'(c + 1);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_y", out_y, 4'hE);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_lu_a", lu_a, 2'b11);
            @(posedge clk);
        end
        @(negedge clk);
        noise = 4'h0;
        out_ready = 1'b1;
        @(posedge clk);                    // handshake
        @(negedge clk);
        out_ready = 1'b0;
        exp_count = (exp_count + 1) % 256;
        chk("stall_op_count", op_count, exp_count);
        chk("stall_in_ready_after", in_ready, 1);
        @(posedge clk);                    // pending command accepted now
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_next_lu_sel", lu_sel, 1);
        chk("stall_next_lu_a", lu_a, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_next_out_y", out_y, 4'hF);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        exp_count = (exp_count + 1) % 256;
        chk("stall_next_op_count", op_count, exp_count);

        // Asynchronous reset mid-DRIVE
        @(negedge clk);
        in_a = 2'b10; in_b = 2'b11; in_sel = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_lu_a", lu_a, 0);
        chk("arst_lu_b", lu_b, 0);
        chk("arst_lu_sel", lu_sel, 0);
        chk("arst_out_y", out_y, 0);
        chk("arst_out_sel", out_sel, 0);
        chk("arst_op_count", op_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        run_cmd(2'b11, 2'b01, 1'b0, 4'hE);

        // Reset, then 256 back-to-back commands with out_ready high
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_a = 2'b01; in_b = 2'b11; in_sel = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        last_pulse = -1;
        pulses = 0;
        for (int i = 0; i < 1024; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (last_pulse >= 0)
                    chk("b2b_spacing", i - last_pulse, 4);
                else
                    chk("b2b_first_pulse", i, 2);
                last_pulse = i;
            end
            if (i == 1019) chk("b2b_count_255", op_count, 255);
            if (i == 1023) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        chk("b2b_pulses", pulses, 256);
        chk("b2b_wrap", op_count, 0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_op_sequencer.md
LOGIC_OP_SEQUENCER -- requirements
Module: logic_op_sequencer

Interface
REQ-001 Parameter: SETTLE, default 2, number of cycles the operands are held on the logic-unit inputs before the result is sampled; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: in_valid  input  1  upstream command valid.
REQ-005 Port: in_ready  output  1  block can accept a command.
REQ-006 Port: in_a  input  2  command operand A.
REQ-007 Port: in_b  input  2  command operand B.
REQ-008 Port: in_sel  input  1  command op select (0 = NAND, 1 = NOT A).
REQ-009 Port: lu_a  output  2  registered operand A, driven to the logic unit A input.
REQ-010 Port: lu_b  output  2  registered operand B, driven to the logic unit B input.
REQ-011 Port: lu_sel  output  1  registered select, driven to the logic unit sel input.
REQ-012 Port: lu_y  input  4  result returned from the logic unit y output.
REQ-013 Port: out_valid  output  1  captured result valid.
REQ-014 Port: out_ready  input  1  downstream accepts the result.
REQ-015 Port: out_y  output  4  captured result.
REQ-016 Port: out_sel  output  1  select of the op that produced out_y.
REQ-017 Port: op_count  output  8  number of completed output handshakes.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, DRIVE and HOLD.
REQ-019 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in HOLD; both SHALL be decoded from state alone, with no combinational input-to-output path.
REQ-020 In IDLE, when in_valid=1 at an edge, the block SHALL latch in_a, in_b and in_sel into lu_a, lu_b and lu_sel, load the settle counter with SETTLE-1, and enter DRIVE.
REQ-021 In IDLE with in_valid=0, the state and all registers SHALL hold.
REQ-022 In DRIVE, lu_a, lu_b and lu_sel SHALL remain stable, and the counter SHALL decrement each cycle.
REQ-023 On the edge where the counter equals 0 in DRIVE, the block SHALL capture lu_y into out_y and lu_sel into out_sel, and enter HOLD.
REQ-024 Latency: for an input handshake at edge N, out_valid SHALL first be 1 after edge N+SETTLE.
REQ-025 In HOLD, out_y and out_sel SHALL stay stable until a handshake occurs (out_valid=1 and out_ready=1 at an edge).
REQ-026 On the output handshake, the block SHALL return to IDLE and increment op_count by 1, wrapping 255 -> 0.
REQ-027 in_valid asserted while the block is in DRIVE or HOLD SHALL be ignored; commands are not queued, and upstream must hold in_valid until in_ready=1.
REQ-028 lu_y SHALL be sampled only on the capture edge of REQ-023; changes on lu_y at any other time SHALL NOT affect out_y.
REQ-029 Throughput: at most one command per SETTLE+2 cycles, with out_ready held at 1.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force: state=IDLE, counter=0, lu_a=0, lu_b=0, lu_sel=0, out_y=0, out_sel=0, op_count=0, out_valid=0, in_ready=1.
REQ-031 Reset asserted mid-DRIVE or mid-HOLD SHALL discard the pending operation without incrementing op_count.
REQ-032 After rst_n deasserts, the first command SHALL be accepted at the first edge with in_valid=1.

Verification
(All scenarios use SETTLE=2 and a live logic unit wired to lu_*/lu_y; the unit computes 4-bit results as ~(A&B) or ~A.)
REQ-033 Command in_a=2'b11, in_b=2'b01, in_sel=0 accepted at edge N -> out_valid=1 after edge N+2, out_y=4'hE, out_sel=0; the output handshake sets op_count=1.
REQ-034 Command in_a=2'b10, in_sel=1 -> out_y=4'hD, out_sel=1.
REQ-035 out_ready held at 0 for 5 cycles in HOLD, with in_valid=1 and lu_y toggling -> out_y stable, in_ready=0, and no new command accepted.
REQ-036 rst_n pulsed low during DRIVE -> all outputs take their reset values asynchronously (before the next edge), op_count=0, and the next command completes normally.
REQ-037 256 back-to-back commands with out_ready=1 -> op_count wraps to 0, and out_valid pulses exactly once per command, spaced every 4 cycles.
